// File: rtl/swi_debouncer.sv
// Switch input conditioner: each raw bit passes through a 2-flop synchronizer and a
// debounce counter, then drives a clean level plus one-cycle rise/fall strobes.
module swi_debouncer #(
  parameter int NBITS           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] swi_stable,
  output logic [NBITS-1:0] swi_rise,
  output logic [NBITS-1:0] swi_fall,
  output logic             swi_change
);

  localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0] sync1;
  logic [NBITS-1:0] sync2;
  logic [NBITS-1:0] stable_next;
  logic [CNT_W-1:0] cnt      [NBITS];
  logic [CNT_W-1:0] cnt_next [NBITS];

  // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing edges; any
  // agreement clears the count, so a glitch restarts from zero.
  always_comb begin
    stable_next = swi_stable;
    for (int i = 0; i < NBITS; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != swi_stable[i]) begin
        if (cnt[i] == CNT_TC) begin
          stable_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      swi_stable <= '0;
      swi_rise   <= '0;
      swi_fall   <= '0;
      for (int i = 0; i < NBITS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= SWI;
      sync2      <= sync1;
      swi_stable <= stable_next;
      // Strobes are registered alongside the new level so they line up with it.
      swi_rise   <= stable_next & ~swi_stable;
      swi_fall   <= ~stable_next & swi_stable;
      for (int i = 0; i < NBITS; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign swi_change = |(swi_rise | swi_fall);

endmodule

// File: tb/tb_swi_debouncer.sv
// Directed bench for swi_debouncer: default 4-cycle instance plus a 1-cycle instance,
// expected values computed by hand from the edge-by-edge latency.
module tb_swi_debouncer;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] SWI   = 8'h00;
  logic [7:0] swi1  = 8'h00;

  logic [7:0] swi_stable, swi_rise, swi_fall;
  logic       swi_change;
  logic [7:0] stable1, rise1, fall1;
  logic       change1;

  int n_tests = 0;
  int n_fail  = 0;

  swi_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .SWI        (SWI),
    .swi_stable (swi_stable),
    .swi_rise   (swi_rise),
    .swi_fall   (swi_fall),
    .swi_change (swi_change)
  );

  swi_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk_2      (clk_2),
    .reset      (reset),
    .SWI        (swi1),
    .swi_stable (stable1),
    .swi_rise   (rise1),
    .swi_fall   (fall1),
    .swi_change (change1)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] st, input logic [7:0] ri,
                           input logic [7:0] fa, input logic ch);
    check({tag, ".stable"}, swi_stable, st);
    check({tag, ".rise"},   swi_rise,   ri);
    check({tag, ".fall"},   swi_fall,   fa);
    check({tag, ".change"}, {7'b0, swi_change}, {7'b0, ch});
  endtask

  initial begin
    // Reset hold
    tick();
    tick();
    check_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    check("reset.stable1", stable1, 8'h00);

    // A5 rise: level appears on the 6th edge
    reset = 1'b0;
    SWI   = 8'hA5;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_all($sformatf("a5_e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    check_all("a5_e6", 8'hA5, 8'hA5, 8'h00, 1'b1);
    tick();
    check_all("a5_e7", 8'hA5, 8'h00, 8'h00, 1'b0);

    // Bit 0 glitch low for 3 edges: rejected
    SWI = 8'hA4;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_all($sformatf("glitch_e%0d", e), 8'hA5, 8'h00, 8'h00, 1'b0);
    end
    SWI = 8'hA5;
    for (int e = 4; e <= 9; e++) begin
      tick();
      check_all($sformatf("glitch_e%0d", e), 8'hA5, 8'h00, 8'h00, 1'b0);
    end

    // A5 -> 5A: simultaneous rise and fall
    SWI = 8'h5A;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_all($sformatf("5a_e%0d", e), 8'hA5, 8'h00, 8'h00, 1'b0);
    end
    tick();
    check_all("5a_e6", 8'h5A, 8'h5A, 8'hA5, 1'b1);
    tick();
    check_all("5a_e7", 8'h5A, 8'h00, 8'h00, 1'b0);

    // Reset mid-count of a 00 -> FF transition
    reset = 1'b1;
    SWI   = 8'h00;
    tick();
    check_all("rst2", 8'h00, 8'h00, 8'h00, 1'b0);
    reset = 1'b0;
    SWI   = 8'hFF;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_all($sformatf("ff_e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    reset = 1'b1;
    tick();
    check_all("ff_rst_edge", 8'h00, 8'h00, 8'h00, 1'b0);
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_all($sformatf("ff_rel_e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    check_all("ff_rel_e6", 8'hFF, 8'hFF, 8'h00, 1'b1);
    tick();
    check_all("ff_rel_e7", 8'hFF, 8'h00, 8'h00, 1'b0);

    // DEBOUNCE_CYCLES=1 instance: flips on edge 3
    swi1 = 8'h03;
    tick();
    check("d1_e1.stable", stable1, 8'h00);
    tick();
    check("d1_e2.stable", stable1, 8'h00);
    check("d1_e2.rise", rise1, 8'h00);
    tick();
    check("d1_e3.stable", stable1, 8'h03);
    check("d1_e3.rise", rise1, 8'h03);
    check("d1_e3.fall", fall1, 8'h00);
    check("d1_e3.change", {7'b0, change1}, 8'h01);
    tick();
    check("d1_e4.rise", rise1, 8'h00);
    check("d1_e4.change", {7'b0, change1}, 8'h00);

    // Bit 7 toggling every edge never settles
    for (int e = 1; e <= 20; e++) begin
      SWI = SWI ^ 8'h80;
      tick();
      check($sformatf("tog_e%0d.stable7", e), {7'b0, swi_stable[7]}, 8'h01);
      check($sformatf("tog_e%0d.pulse7", e), {6'b0, swi_rise[7], swi_fall[7]}, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/swi_debouncer.md
Name: swi_debouncer

Overview:
- Input-conditioning stage that sits directly upstream of the lab top-level mode logic.
- Takes the raw SWI slide switches and passes each bit through a 2-flop synchronizer and a per-bit debounce counter.
- Delivers clean levels plus one-cycle rise/fall pulses to the downstream logic: mode select f, reset, serial/parallel select, and serial/parallel data.
- Downstream logic consumes swi_stable in place of SWI and uses swi_rise/swi_fall as single-step strobes for the shift register and RAM write.

Parameters:
- NBITS, 8, number of switch bits conditioned.
- DEBOUNCE_CYCLES, 4, consecutive clk_2 edges a synchronized bit must differ from its stable value before the stable value flips. Legal range 1..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived; not overridden.

Ports:
- clk_2  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- SWI  input  NBITS  raw asynchronous switch levels.
- swi_stable  output  NBITS  debounced switch levels.
- swi_rise  output  NBITS  per-bit one-cycle pulse: stable bit went 0->1.
- swi_fall  output  NBITS  per-bit one-cycle pulse: stable bit went 1->0.
- swi_change  output  1  OR-reduction of (swi_rise | swi_fall).

Behaviour:
- Reset (reset=1 at a rising edge), all state cleared:
  - sync1, sync2, swi_stable, swi_rise, swi_fall, all counters = 0.
  - swi_change = 0.
  - Reset overrides every other update, including mid-count: counters are discarded and no pulse is produced on the reset edge or on the first edge after release.
- Synchronizer, per edge: sync1 <= SWI; sync2 <= sync1. No logic is placed between the two flops.
- Debounce, per bit i, per edge (reset=0):
  - If sync2[i] == swi_stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: swi_stable[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Pulses, registered:
  - swi_rise[i] <= 1 only on the edge where swi_stable[i] flips 0->1; otherwise 0.
  - swi_fall[i] <= 1 only on the edge where swi_stable[i] flips 1->0; otherwise 0.
  - Each pulse is high for exactly one cycle and is coincident with the new swi_stable value.
- swi_change is combinational from the registered swi_rise/swi_fall.
- Latency: a SWI change held steady and captured at edge E1 appears on swi_stable at edge E(2+DEBOUNCE_CYCLES). With the default, that is the 6th edge.
- Glitch rejection: if sync2[i] returns to swi_stable[i] before the count completes, the counter clears with no output change. A later disagreement restarts counting from 0.
- Bits are fully independent. Several bits may flip on the same edge, and their rise/fall pulses assert together.
- DEBOUNCE_CYCLES=1: the stable value flips on the first differing edge, giving a latency of 3 edges.
- Counters never exceed DEBOUNCE_CYCLES-1, so there is no wrap.
- After reset, switches already high produce a normal rise pulse once the latency elapses.

Test Plan:
- Reset hold, then SWI=8'hA5 held: edges 1-5 give swi_stable=8'h00. Edge 6 gives swi_stable=8'hA5, swi_rise=8'hA5, swi_change=1. Edge 7 gives swi_rise=8'h00.
- From stable 8'hA5, SWI[0]=0 for 3 edges then back to 1: swi_stable stays 8'hA5, and swi_fall and swi_change stay 0 throughout.
- From stable 8'hA5, SWI=8'h5A held: edge 6 gives swi_stable=8'h5A, swi_rise=8'h5A, swi_fall=8'hA5, all for one cycle.
- Reset asserted at edge 4 of an 8'h00->8'hFF transition, released next edge, SWI held at 8'hFF: no pulses on the reset edge or the first edge after release. swi_stable=8'hFF and swi_rise=8'hFF at the 6th edge after release.
- DEBOUNCE_CYCLES=1, SWI 8'h00->8'h03: swi_stable=8'h03 and swi_rise=8'h03 at edge 3.
- SWI[7] toggled every edge for 20 edges: swi_stable[7] never changes and no pulses appear on bit 7.
